// File: rtl/mdu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_issue_ctrl
// Description : Issue controller for the execute-stage multiply/divide unit.
//               Launches MDU operations, tracks their latency with a
//               down-counter, raises the HI/LO commit strobe in the last busy
//               cycle, and produces the D-stage stall for HI/LO consumers.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_issue_ctrl #(
  parameter int MULT_LAT = 5,   // busy cycles for mult/multu
  parameter int DIV_LAT  = 10,  // busy cycles for div/divu
  parameter int CNT_W    = 4    // latency counter width
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       md_req_E,
  input  logic [1:0] md_kind_E,
  input  logic       hl_use_D,
  input  logic       hl_wr_E,
  output logic       start,
  output logic [2:0] mdu_op,
  output logic       busy,
  output logic       commit,
  output logic       stall_D,
  output logic       proto_err
);

  // Load values for the latency counter, sized once to the counter width.
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Remaining busy cycles; zero means the MDU is idle. This is the whole
  // scheduler state: IDLE is cnt==0, RUN is cnt!=0.
  logic [CNT_W-1:0] cnt;
  logic             viol;

  // busy and commit come straight off the counter, so neither has a path
  // from any input. start is the only combinational issue decision.
  assign busy    = (cnt != '0);
  assign commit  = (cnt == CNT_ONE);
  assign start   = md_req_E & ~busy;
  assign stall_D = hl_use_D & (start | busy);

  // A new MDU request or an mthi/mtlo while an operation is in flight would
  // clobber HI/LO ordering; such requests are flagged and otherwise ignored.
  assign viol = busy & (md_req_E | hl_wr_E);

  // Latency counter: load on launch, count down while running, hold at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= md_kind_E[1] ? DIV_CNT : MULT_CNT;
    end else if (busy) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  // Operation code presented to the MDU; held until the next launch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdu_op <= 3'b000;
    end else if (start) begin
      mdu_op <= {1'b0, md_kind_E};
    end
  end

  // Sticky protocol-violation flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      proto_err <= 1'b0;
    end else if (viol) begin
      proto_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_issue_ctrl
// Description : Scoreboard bench for mdu_issue_ctrl. The stimulus process
//               drives one cycle of inputs and queues the hand-computed
//               outputs for that cycle; the monitor samples the DUT on the
//               falling edge and compares against the queue head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_issue_ctrl;

  logic       clk;
  logic       reset;
  logic       md_req_E;
  logic [1:0] md_kind_E;
  logic       hl_use_D;
  logic       hl_wr_E;
  logic       start;
  logic [2:0] mdu_op;
  logic       busy;
  logic       commit;
  logic       stall_D;
  logic       proto_err;

  mdu_issue_ctrl #(
    .MULT_LAT(5),
    .DIV_LAT (10),
    .CNT_W   (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .md_req_E (md_req_E),
    .md_kind_E(md_kind_E),
    .hl_use_D (hl_use_D),
    .hl_wr_E  (hl_wr_E),
    .start    (start),
    .mdu_op   (mdu_op),
    .busy     (busy),
    .commit   (commit),
    .stall_D  (stall_D),
    .proto_err(proto_err)
  );

  // Expected output word: {start, busy, commit, stall_D, mdu_op[2:0], proto_err}
  typedef struct {
    string      nm;
    int         cyc;
    logic [7:0] v;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: compare DUT outputs at mid-cycle against the queued expectation.
  initial begin
    exp_t       e;
    logic [7:0] got;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        got = {start, busy, commit, stall_D, mdu_op, proto_err};
        total++;
        if (got !== e.v) begin
          bad++;
          $display("FAIL %s c%0d: got start=%b busy=%b commit=%b stall=%b op=%b err=%b, exp start=%b busy=%b commit=%b stall=%b op=%b err=%b",
                   e.nm, e.cyc, got[7], got[6], got[5], got[4], got[3:1], got[0],
                   e.v[7], e.v[6], e.v[5], e.v[4], e.v[3:1], e.v[0]);
        end
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected in that cycle.
  task automatic step(input string nm, input int cyc,
                      input logic rq, input logic [1:0] k,
                      input logic u, input logic w,
                      input logic es, input logic eb, input logic ec,
                      input logic ed, input logic [2:0] eo, input logic ee);
    exp_t e;
    @(posedge clk);
    #1;
    md_req_E  = rq;
    md_kind_E = k;
    hl_use_D  = u;
    hl_wr_E   = w;
    e.nm  = nm;
    e.cyc = cyc;
    e.v   = {es, eb, ec, ed, eo, ee};
    q.push_back(e);
  endtask

  // Pulse reset across one clock edge with idle inputs; no checks queued.
  task automatic pulse_reset();
    @(posedge clk);
    #1;
    md_req_E = 1'b0;
    hl_use_D = 1'b0;
    hl_wr_E  = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    int wait_cyc;
    reset     = 1'b1;
    md_req_E  = 1'b0;
    md_kind_E = 2'b00;
    hl_use_D  = 1'b0;
    hl_wr_E   = 1'b0;

    // Reset state.
    step("reset", 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    step("reset", 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    reset = 1'b0;

    // mult: start c0, busy c1..c5, commit c5, idle c6.
    step("mult", 0, 1, 2'b00, 0, 0, 1, 0, 0, 0, 3'b000, 0);
    for (int c = 1; c <= 6; c++)
      step("mult", c, 0, 2'b00, 0, 0, 0, (c <= 5), (c == 5), 0, 3'b000, 0);

    // divu with mflo in D: stall c0..c10, commit c10, stall drops c11.
    step("divu", 0, 1, 2'b11, 1, 0, 1, 0, 0, 1, 3'b000, 0);
    for (int c = 1; c <= 11; c++)
      step("divu", c, 0, 2'b00, 1, 0, 0, (c <= 10), (c == 10), (c <= 10), 3'b011, 0);

    // div, then a second request in the commit cycle: refused, error flagged.
    step("div_ovl", 0, 1, 2'b10, 0, 0, 1, 0, 0, 0, 3'b011, 0);
    for (int c = 1; c <= 9; c++)
      step("div_ovl", c, 0, 2'b00, 0, 0, 0, 1, 0, 0, 3'b010, 0);
    step("div_ovl", 10, 1, 2'b00, 0, 0, 0, 1, 1, 0, 3'b010, 0);
    step("div_ovl", 11, 0, 2'b00, 0, 0, 0, 0, 0, 0, 3'b010, 1);
    step("div_ovl", 12, 0, 2'b00, 0, 0, 0, 0, 0, 0, 3'b010, 1);

    // multu, then reset mid-cycle c3: everything clears, no commit later.
    step("rst_mid", 0, 1, 2'b01, 0, 0, 1, 0, 0, 0, 3'b010, 1);
    step("rst_mid", 1, 0, 2'b00, 0, 0, 0, 1, 0, 0, 3'b001, 1);
    step("rst_mid", 2, 0, 2'b00, 0, 0, 0, 1, 0, 0, 3'b001, 1);
    step("rst_mid", 3, 0, 2'b00, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    #2;
    reset = 1'b1;
    step("rst_mid", 4, 0, 2'b00, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    reset = 1'b0;
    for (int c = 5; c <= 7; c++)
      step("rst_mid", c, 0, 2'b00, 0, 0, 0, 0, 0, 0, 3'b000, 0);

    // mthi/mtlo during a mult: flagged, counting and commit unaffected.
    step("hlwr", 0, 1, 2'b00, 0, 0, 1, 0, 0, 0, 3'b000, 0);
    step("hlwr", 1, 0, 2'b00, 0, 0, 0, 1, 0, 0, 3'b000, 0);
    step("hlwr", 2, 0, 2'b00, 0, 1, 0, 1, 0, 0, 3'b000, 0);
    for (int c = 3; c <= 6; c++)
      step("hlwr", c, 0, 2'b00, 0, 0, 0, (c <= 5), (c == 5), 0, 3'b000, 1);

    pulse_reset();

    // div, then a clean back-to-back mult one cycle after busy falls.
    step("b2b", 0, 1, 2'b10, 0, 0, 1, 0, 0, 0, 3'b000, 0);
    for (int c = 1; c <= 10; c++)
      step("b2b", c, 0, 2'b00, 0, 0, 0, 1, (c == 10), 0, 3'b010, 0);
    step("b2b", 11, 1, 2'b00, 0, 0, 1, 0, 0, 0, 3'b010, 0);
    for (int c = 12; c <= 17; c++)
      step("b2b", c, 0, 2'b00, 0, 0, 0, (c <= 16), (c == 16), 0, 3'b000, 0);

    // HI/LO user in D while idle does not stall; it does in a start cycle.
    step("stall", 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 3'b000, 0);
    step("stall", 1, 1, 2'b01, 1, 0, 1, 0, 0, 1, 3'b000, 0);
    for (int c = 2; c <= 7; c++)
      step("stall", c, 0, 2'b00, 0, 0, 0, (c <= 6), (c == 6), 0, 3'b001, 0);

    // Request and mthi/mtlo together while idle: launch proceeds, no error.
    step("both", 0, 1, 2'b10, 0, 1, 1, 0, 0, 0, 3'b001, 0);
    for (int c = 1; c <= 11; c++)
      step("both", c, 0, 2'b00, 0, 0, 0, (c <= 10), (c == 10), 0, 3'b010, 0);

    // Let the monitor drain the queue, bounded.
    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    @(posedge clk);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- Issue controller and scheduler for the multiply/divide unit (MDU) in the execute stage.
- Accepts mult/multu/div/divu requests from the E-stage decoder and generates the MDU start pulse.
- Counts the operation latency, drives busy, and emits a one-cycle HI/LO commit strobe.
- Produces the D-stage stall consumed by the hazard unit; it holds no operands, and arithmetic stays in the MDU.

Parameters:
- MULT_LAT, 5, busy cycles for mult/multu (legal range 1..2^CNT_W-1)
- DIV_LAT, 10, busy cycles for div/divu (legal range 1..2^CNT_W-1)
- CNT_W, 4, latency counter width

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- md_req_E  input  1  valid mult/multu/div/divu in E this cycle (low for a bubble)
- md_kind_E  input  2  00 mult, 01 multu, 10 div, 11 divu
- hl_use_D  input  1  D-stage instr reads or writes HI/LO or is an MDU op (mult*, div*, mfhi, mflo, mthi, mtlo)
- hl_wr_E  input  1  valid mthi/mtlo in E
- start  output  1  one-cycle MDU launch pulse
- mdu_op  output  3  latched op to MDU: {1'b0, kind} of the last accepted start; 3'b000 after reset
- busy  output  1  MDU occupied
- commit  output  1  HI/LO write enable for the MDU result
- stall_D  output  1  freeze F/D and bubble E
- proto_err  output  1  sticky protocol-violation flag

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: cnt=0, mdu_op=000, proto_err=0. Therefore busy=0, commit=0 and start=0 once md_req_E is low.
- States:
  - IDLE: cnt==0.
  - RUN: cnt!=0.
  - busy = (cnt!=0), a register-derived signal with no combinational path from inputs.
- start (combinational): start = md_req_E & ~busy.
- On a clock edge with start=1:
  - cnt <= MULT_LAT if md_kind_E[1]==0, else DIV_LAT.
  - mdu_op <= {1'b0, md_kind_E}.
- In RUN, each edge: cnt <= cnt-1.
- commit (combinational) = (cnt==1). It is high during the last busy cycle, so HI/LO update on the same edge at which busy falls.
- Latency: start in cycle T, busy high in cycles T+1..T+LAT, commit high in cycle T+LAT, busy low from T+LAT+1.
- Back-to-back: a new md_req_E in cycle T+LAT+1 gets start=1.
- Back-to-back: md_req_E in cycle T+LAT (commit cycle) gets start=0, because busy=1 in that cycle.
- stall_D = hl_use_D & (start | busy). This covers an MDU instr in D behind a just-started op and also mfhi/mflo reading before commit.
- Protocol errors:
  - Triggers: md_req_E & busy, or hl_wr_E & busy.
  - Effect: proto_err <= 1 at the edge, and it stays set until reset.
  - The offending request is ignored: no start, cnt and mdu_op unchanged.
- A simultaneous md_req_E and hl_wr_E in IDLE cannot occur from one E instr. If both are presented, start proceeds and proto_err is not set.
- Counter never wraps. cnt=0 holds at 0, and loads only occur from IDLE.
- Reset mid-operation: cnt cleared immediately (asynchronous), so busy and commit drop with no commit pulse. mdu_op returns to 000 and proto_err clears.
- mdu_op holds after completion until the next start.

Test Plan:
- Reset, then mult (kind 00) in cycle 0 -> start=1 in c0; busy=1 in c1..c5; commit=1 only in c5; busy=0 from c6; mdu_op=000.
- divu (kind 11) in c0 with hl_use_D=1 (mflo) in c0..c10 -> mdu_op=011; stall_D=1 in c0..c10; commit in c10; stall_D=0 in c11.
- div in c0, second md_req_E in c10 -> start=0 in c10 and proto_err=1 from c11. Separately, with no error injected, a second mult in c11 -> start=1 and busy in c12..c16.
- mult in c0, reset asserted mid-cycle c3 -> busy=0 and commit=0 immediately, no commit pulse afterwards, mdu_op=000, proto_err=0.
- hl_wr_E=1 during busy (c2 of a mult) -> proto_err=1 from the next edge; cnt sequence unaffected and commit still in c5.
- Idle with hl_use_D=1 and md_req_E=0 -> stall_D=0; md_req_E pulsed with hl_use_D=1 -> stall_D=1 in the start cycle.
